// File: rtl/piece_sequencer_if.sv
// piece_sequencer_if: command/status bundle between the game-flow sequencer and the board datapath.
interface piece_sequencer_if;
    logic       start;
    logic [7:0] keycode;
    logic       can_left, can_right, can_rotate, can_down;
    logic       spawn_ok, lines_done;
    logic [2:0] state;
    logic       do_left, do_right, do_rotate, do_down, do_spawn, do_lock, do_clear;
    logic       game_over;
    modport master (
        input  start, keycode, can_left, can_right, can_rotate, can_down, spawn_ok, lines_done,
        output state, do_left, do_right, do_rotate, do_down, do_spawn, do_lock, do_clear, game_over
    );
    modport slave (
        output start, keycode, can_left, can_right, can_rotate, can_down, spawn_ok, lines_done,
        input  state, do_left, do_right, do_rotate, do_down, do_spawn, do_lock, do_clear, game_over
    );
endinterface

// File: rtl/piece_sequencer.sv
// piece_sequencer: spawn/gravity/move/lock/clear flow turning keys and a gravity timer into one-cycle command pulses.
module piece_sequencer #(
    parameter int unsigned GRAVITY_TICKS   = 25_000_000,
    parameter int unsigned SOFT_DROP_TICKS = 2_500_000,
    parameter int unsigned REPEAT_DELAY    = 8_000_000,
    parameter int unsigned REPEAT_RATE     = 2_000_000,
    parameter int unsigned SETTLE          = 8
) (
    input  logic              Clk,
    input  logic              reset,
    piece_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b000, SPAWN = 3'b001, SPAWN_CHK = 3'b101, ACTIVE = 3'b111,
        LOCK = 3'b010, CLEAR = 3'b011, OVER = 3'b100
    } state_t;
    localparam logic [7:0] KEY_LEFT = 8'h04, KEY_RIGHT = 8'h07, KEY_ROT = 8'h1A, KEY_SOFT = 8'h16;
    localparam int P_LEFT = 6, P_RIGHT = 5, P_ROT = 4, P_DOWN = 3, P_SPAWN = 2, P_LOCK = 1, P_CLEAR = 0;
    // Repeat timer counts down to the next repeat; a delay of 1 makes the press itself the first repeat.
    localparam logic [31:0] REP_FIRST = (REPEAT_DELAY == 1) ? REPEAT_RATE : REPEAT_DELAY - 1;
    state_t      state_q, state_d;
    logic [31:0] grav_q, grav_d, rep_q, rep_d, settle_q, settle_d;
    logic [7:0]  prev_key_q, prev_key_d, pend_key_q, pend_key_d;
    logic [6:0]  pulse_q, pulse_d;
    logic        game_over_q, game_over_d;
    logic        action_key, press, repeat_ev, due;
    logic [31:0] period;
    logic [7:0]  ev_key;
    always_comb begin
        action_key = bus.keycode inside {KEY_LEFT, KEY_RIGHT, KEY_ROT};
        press      = action_key && bus.keycode != prev_key_q;
        repeat_ev  = action_key && !press && rep_q == 32'd1;
        period     = (bus.keycode == KEY_SOFT) ? SOFT_DROP_TICKS : GRAVITY_TICKS;
        due        = grav_q >= period - 32'd1;
        ev_key     = (press || repeat_ev) ? bus.keycode : pend_key_q;
        state_d    = state_q;
        pulse_d    = '0;
        prev_key_d = bus.keycode;
        rep_d      = !action_key ? '0 : press ? REP_FIRST : repeat_ev ? REPEAT_RATE :
                     (rep_q == '0) ? '0 : rep_q - 32'd1;
        grav_d     = grav_q;
        settle_d   = settle_q;
        pend_key_d = pend_key_q;
        case (state_q)
            IDLE:      state_d = bus.start ? SPAWN : IDLE;
            SPAWN:     state_d = SPAWN_CHK;
            SPAWN_CHK: begin
                state_d    = bus.spawn_ok ? ACTIVE : OVER;
                grav_d     = '0;
                rep_d      = '0;
                settle_d   = '0;
                pend_key_d = '0;
            end
            ACTIVE: begin
                grav_d = due ? grav_q : grav_q + 32'd1;
                if (settle_q != '0) begin
                    settle_d   = settle_q - 32'd1;
                    pend_key_d = press ? bus.keycode : pend_key_q;
                end else begin
                    pend_key_d = '0;
                    if (due) begin
                        grav_d = '0;
                        if (bus.can_down) pulse_d[P_DOWN] = 1'b1;
                        else state_d = LOCK;
                    end
                    else if (ev_key == KEY_ROT && bus.can_rotate) pulse_d[P_ROT] = 1'b1;
                    else if (ev_key == KEY_LEFT && bus.can_left) pulse_d[P_LEFT] = 1'b1;
                    else if (ev_key == KEY_RIGHT && bus.can_right) pulse_d[P_RIGHT] = 1'b1;
                    settle_d = |pulse_d[P_LEFT:P_DOWN] ? SETTLE : '0;
                end
            end
            LOCK:      state_d = CLEAR;
            CLEAR:     state_d = bus.lines_done ? SPAWN : CLEAR;
            OVER:      state_d = bus.start ? IDLE : OVER;
            default:   state_d = IDLE;
        endcase
        pulse_d[P_SPAWN] = state_d == SPAWN;
        pulse_d[P_LOCK]  = state_d == LOCK;
        pulse_d[P_CLEAR] = state_d == CLEAR && state_q != CLEAR;
        game_over_d      = state_d == OVER;
    end
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grav_q      <= '0;
            rep_q       <= '0;
            settle_q    <= '0;
            prev_key_q  <= '0;
            pend_key_q  <= '0;
            pulse_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grav_q      <= grav_d;
            rep_q       <= rep_d;
            settle_q    <= settle_d;
            prev_key_q  <= prev_key_d;
            pend_key_q  <= pend_key_d;
            pulse_q     <= pulse_d;
            game_over_q <= game_over_d;
        end
    end
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;
    assign {bus.do_left, bus.do_right, bus.do_rotate, bus.do_down,
            bus.do_spawn, bus.do_lock, bus.do_clear} = pulse_q;
endmodule
